// File: rtl/yolo_s2mm_packer.sv
// Byte-to-64-bit packer feeding the S2MM AXI4-Stream port.
// A show-ahead beat FIFO absorbs DMA backpressure.
module yolo_s2mm_packer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        start,
    input  logic [23:0] byte_len,
    input  logic [7:0]  pix_data,
    input  logic        pix_vld,
    output logic        pix_rdy,
    output logic [63:0] m_axis_s2mm_tdata,
    output logic [7:0]  m_axis_s2mm_tkeep,
    output logic        m_axis_s2mm_tvalid,
    input  logic        m_axis_s2mm_tready,
    output logic        m_axis_s2mm_tlast,
    output logic        busy,
    output logic        task_finish
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t      state;
    logic [23:0] remain;
    logic [2:0]  lane;
    logic [63:0] pack;

    logic [63:0] mem_data [FIFO_DEPTH];
    logic [7:0]  mem_keep [FIFO_DEPTH];
    logic        mem_last [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic        fifo_full;
    logic        fifo_empty;
    logic        byte_acc;
    logic        push;
    logic        pop;
    logic        last_byte;
    logic [63:0] pack_next;
    logic [7:0]  keep_next;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));

    assign pix_rdy   = (state == RUN) && !fifo_full;
    assign byte_acc  = pix_vld && pix_rdy;
    assign last_byte = (remain == 24'd1);
    assign push      = byte_acc && ((lane == 3'd7) || last_byte);
    assign pop       = m_axis_s2mm_tvalid && m_axis_s2mm_tready;

    // Lanes above the current byte stay zero because pack clears after each push.
    assign pack_next = pack | ({56'd0, pix_data} << {lane, 3'b000});
    assign keep_next = 8'hFF >> (3'd7 - lane);

    // Gate the head entry so an empty FIFO presents all-zero beat fields.
    assign m_axis_s2mm_tvalid = !fifo_empty;
    assign m_axis_s2mm_tdata  = fifo_empty ? 64'd0 : mem_data[rd_ptr];
    assign m_axis_s2mm_tkeep  = fifo_empty ? 8'd0  : mem_keep[rd_ptr];
    assign m_axis_s2mm_tlast  = fifo_empty ? 1'b0  : mem_last[rd_ptr];
    assign busy               = (state != IDLE);

    // Task sequencing: byte lane tracking, pack register and finish pulse.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= IDLE;
            remain      <= '0;
            lane        <= '0;
            pack        <= '0;
            task_finish <= 1'b0;
        end else begin
            task_finish <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && (byte_len != 24'd0)) begin
                        remain <= byte_len;
                        lane   <= '0;
                        pack   <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (byte_acc) begin
                        remain <= remain - 24'd1;
                        lane   <= lane + 3'd1;
                        pack   <= push ? 64'd0 : pack_next;
                        if (last_byte) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_axis_s2mm_tlast) begin
                        state       <= IDLE;
                        task_finish <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem_data[wr_ptr] <= pack_next;
            mem_keep[wr_ptr] <= keep_next;
            mem_last[wr_ptr] <= last_byte;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_yolo_s2mm_packer.sv
// Randomized self-checking bench for yolo_s2mm_packer.
// Expected beats are built from the byte list of each task.
module tb_yolo_s2mm_packer;

    logic        sclk = 1'b0;
    logic        s_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] byte_len = '0;
    logic [7:0]  pix_data = '0;
    logic        pix_vld = 1'b0;
    logic        pix_rdy;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        m_tready = 1'b0;
    logic        tlast;
    logic        busy;
    logic        task_finish;

    int errors = 0;
    int checks = 0;

    yolo_s2mm_packer #(.FIFO_DEPTH(16)) dut (
        .sclk               (sclk),
        .s_rst_n            (s_rst_n),
        .start              (start),
        .byte_len           (byte_len),
        .pix_data           (pix_data),
        .pix_vld            (pix_vld),
        .pix_rdy            (pix_rdy),
        .m_axis_s2mm_tdata  (tdata),
        .m_axis_s2mm_tkeep  (tkeep),
        .m_axis_s2mm_tvalid (tvalid),
        .m_axis_s2mm_tready (m_tready),
        .m_axis_s2mm_tlast  (tlast),
        .busy               (busy),
        .task_finish        (task_finish)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_rdy"}, pix_rdy, 0);
        chk({tag, "_tvalid"}, tvalid, 0);
        chk({tag, "_tdata"}, tdata, 0);
        chk({tag, "_tkeep"}, tkeep, 0);
        chk({tag, "_tlast"}, tlast, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, task_finish, 0);
    endtask

    // n bytes; vld/rdy percentages; rnd selects random bytes;
    // hold = cycles with tready forced low; mid_start = cycle of a
    // stray start pulse; abort_beats = leave after that many beats.
    task automatic run_task(input int n, input int vld_pct, input int rdy_pct,
                            input bit rnd, input int hold,
                            input int mid_start, input int abort_beats);
        logic [7:0]  bytes[$];
        logic [63:0] ed[$];
        logic [7:0]  ek[$];
        logic [63:0] d;
        logic [7:0]  k;
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        bit          pv;
        bit          pr;
        bit          last_prev;
        bit          done;
        int          nb;
        int          sent;
        int          beats;
        int          cyc;

        for (int i = 0; i < n; i++)
            bytes.push_back(rnd ? 8'($urandom) : 8'(i));
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 8; j++) begin
                if (8 * b + j < n) begin
                    d[8*j +: 8] = bytes[8*b+j];
                    k[j] = 1'b1;
                end
            end
            ed.push_back(d);
            ek.push_back(k);
        end

        @(negedge sclk);
        start = 1'b1;
        byte_len = 24'(n);
        pix_vld = 1'b0;
        m_tready = 1'b0;
        @(negedge sclk);
        start = 1'b0;
        #1;
        chk("busy_after_start", busy, 1);

        sent = 0; beats = 0; cyc = 0;
        pv = 0; pr = 0; pd = '0; pk = '0; pl = 0;
        last_prev = 0; done = 0;
        while (!done) begin
            @(negedge sclk);
            start = (mid_start > 0) && (cyc == mid_start);
            if (start) byte_len = 24'd24;
            pix_vld = (sent < n) && ($urandom_range(99) < vld_pct);
            pix_data = pix_vld ? bytes[sent] : 8'h00;
            m_tready = (cyc >= hold) && ($urandom_range(99) < rdy_pct);
            #1;
            if (pv && !pr) begin
                chk("stall_tvalid", tvalid, 1);
                chk("stall_tdata", tdata, pd);
                chk("stall_tkeep", tkeep, pk);
                chk("stall_tlast", tlast, pl);
            end
            if (task_finish || last_prev) begin
                chk("finish_timing", task_finish, last_prev);
                if (task_finish) begin
                    chk("finish_beats", beats, nb);
                    chk("busy_after_finish", busy, 0);
                    done = 1;
                end
            end
            last_prev = 0;
            if (hold > 0 && cyc == hold - 1) begin
                chk("stall_bytes", sent, 128);
                chk("stall_pix_rdy", pix_rdy, 0);
            end
            if (!done) begin
                if (pix_vld && pix_rdy) sent++;
                if (tvalid && m_tready) begin
                    if (beats < nb) begin
                        chk("beat_data", tdata, ed[beats]);
                        chk("beat_keep", tkeep, ek[beats]);
                        chk("beat_last", tlast, beats == nb - 1);
                    end else begin
                        chk("extra_beat", beats, nb);
                    end
                    if (tlast) last_prev = 1;
                    beats++;
                end
                pv = tvalid; pr = m_tready;
                pd = tdata; pk = tkeep; pl = tlast;
                if (abort_beats > 0 && beats >= abort_beats) done = 1;
            end
            cyc++;
            if (cyc > 20000) begin
                chk("timeout", 1, 0);
                done = 1;
            end
        end
        start = 1'b0;
        pix_vld = 1'b0;
        m_tready = 1'b0;
        if (abort_beats == 0) begin
            @(negedge sclk);
            #1;
            chk("finish_pulse_len", task_finish, 0);
            chk("idle_tvalid", tvalid, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge sclk);
        #1;
        chk_all_zero("reset");
        s_rst_n = 1'b1;

        run_task(16, 100, 100, 0, 0, 0, 0);
        run_task(11, 100, 100, 0, 0, 0, 0);
        run_task(1, 100, 100, 0, 0, 0, 0);
        run_task(256, 100, 100, 0, 200, 0, 0);
        run_task(1000, 70, 50, 1, 0, 0, 0);

        @(negedge sclk);
        start = 1'b1;
        byte_len = 24'd0;
        @(negedge sclk);
        start = 1'b0;
        repeat (10) begin
            @(negedge sclk);
            #1;
            chk("zero_len_busy", busy, 0);
            chk("zero_len_tvalid", tvalid, 0);
            chk("zero_len_finish", task_finish, 0);
        end

        run_task(40, 100, 100, 1, 0, 5, 0);

        run_task(64, 100, 100, 1, 0, 0, 3);
        @(negedge sclk);
        s_rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge sclk);
        #1;
        chk_all_zero("held_reset");
        s_rst_n = 1'b1;
        run_task(8, 100, 100, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
